sw_mem_arbiter: RTL and testbench
=================================

Name: sw_mem_arbiter

Overview:
- Shares the single external SRAM read port (select_T / addr / data) between two burst requesters inside the Smith-Waterman core.
- Requester T is the target loader; requester Q is the query loader.
- Each grant owns the port for one whole burst. The arbiter drives select_T_o/addr_o, registers returning words and routes them to the owner with valid/last flags.
- Sits between the loaders and the top-level SmithWaterman memory pins.

Parameters:
- ADDR_W, `SRAM_ADDR_BIT: SRAM address width.
- DATA_W, `SRAM_WORD_WIDTH: SRAM word width.
- LEN_W, 8: burst length field width; a burst is len+1 words (1..2^LEN_W).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- t_req_i  in  1  target burst request, held until t_gnt_o.
- t_addr_i  in  ADDR_W  target burst base address.
- t_len_i  in  LEN_W  target burst words minus 1.
- t_gnt_o  out  1  one-cycle grant pulse.
- t_valid_o  out  1  t_data_o holds a burst word.
- t_last_o  out  1  final word of the target burst (qualified by t_valid_o).
- t_data_o  out  DATA_W  returned word.
- q_req_i, q_addr_i, q_len_i, q_gnt_o, q_valid_o, q_last_o, q_data_o: same as the t_ ports, for the query loader.
- select_T_o  out  1  1 = T memory, 0 = Q memory.
- addr_o  out  ADDR_W  SRAM read address (registered).
- data_i  in  DATA_W  SRAM word for the current addr_o, valid before the next rising edge.
- busy_o  out  1  a burst is in progress.

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer = "T served last", so Q wins the first tie.
- Reset asserted mid-burst: the burst is abandoned; no valid/last is produced after reset release.
- States:
  - IDLE -> RUN on acceptance.
  - RUN -> DRAIN after the last address is issued.
  - DRAIN -> IDLE after the last word is registered.
- Acceptance (in IDLE only): at rising edge E0 with one or more req high.
  - Winner: the sole requester; on a tie, the requester not served last.
  - After E0: winner gnt=1 for exactly one cycle; base and len latched; select_T_o=1 for T, 0 for Q; addr_o=base; busy_o=1.
- Word timing:
  - After edge E(i) (i=0..len), addr_o = base+i, wrapping modulo 2^ADDR_W.
  - At E(i+1), data_i is registered into the owner's data_o with valid=1.
  - last=1 together with word len, after E(len+1).
  - Non-owner valid/last/data stay 0.
- DRAIN: select_T_o and addr_o hold their last values; after E(len+1) state=IDLE and busy_o=0.
- Earliest next acceptance: E(len+2), i.e. one cycle between the final valid and the next grant's first valid cycle.
- Requests while busy_o=1 are not sampled; a req held across the burst is served after it.
- Round-robin: the pointer updates at each acceptance; the loser of a tie is served next if it is still requesting.
- A req dropped before its gnt is never served; no partial burst.
- len=0: single word. gnt after E0, valid+last after E1, busy_o low after E1.
- len=2^LEN_W-1: 256 words with LEN_W=8; the counter must not overflow before last.
- Outputs are glitch-free registers; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: SW_ARB_FIXED_PRI_EN.
- Defined: fixed priority; Q always wins a tie and the round-robin pointer is removed.
- Undefined: round-robin as above.
- All timing is identical in both modes.

Test Plan:
- Reset then t_req_i=1, t_addr_i=10, t_len_i=3:
  - t_gnt_o pulses after E0; addr_o=10,11,12,13 after E0..E3; select_T_o=1.
  - t_valid_o high after E1..E4 with data T_mem[10..13]; t_last_o with the word from 13; busy_o low after E4.
- t_req_i and q_req_i both high at the same edge right after reset, len=1 each:
  - Q served first (select_T_o=0), then T; T's gnt at E3.
  - Repeating the tie afterwards alternates Q, T.
  - With SW_ARB_FIXED_PRI_EN defined, Q wins every tie.
- q_addr_i=2^ADDR_W-2, q_len_i=3 -> addr_o sequence max-1, max, 0, 1; four valid words, last on the fourth.
- t_len_i=0 -> one-word burst; t_valid_o and t_last_o high together for exactly one cycle.
- rst_n pulled low after word 2 of an 8-word burst -> all outputs 0 immediately; no further valid after release; a fresh request is granted normally.
- q_req_i raised during a T burst and held -> q_gnt_o exactly one cycle after T's last valid; no overlap of t_valid_o and q_valid_o.

Source files
------------

// File: rtl/sw_mem_arbiter.sv
// sw_mem_arbiter: shares the external SRAM read port between the target (T)
// and query (Q) burst loaders of the Smith-Waterman core. Each grant owns the
// port for a whole burst of len+1 words; returned words are registered and
// routed to the owner with valid/last flags.
// Optional build macro SW_ARB_FIXED_PRI_EN: Q always wins a tie and the
// round-robin pointer is removed. Without it, ties alternate round-robin.
`ifndef SRAM_ADDR_BIT
`define SRAM_ADDR_BIT 10
`endif
`ifndef SRAM_WORD_WIDTH
`define SRAM_WORD_WIDTH 16
`endif

module sw_mem_arbiter #(
  parameter int ADDR_W = `SRAM_ADDR_BIT,
  parameter int DATA_W = `SRAM_WORD_WIDTH,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              t_req_i,
  input  logic [ADDR_W-1:0] t_addr_i,
  input  logic [LEN_W-1:0]  t_len_i,
  output logic              t_gnt_o,
  output logic              t_valid_o,
  output logic              t_last_o,
  output logic [DATA_W-1:0] t_data_o,
  input  logic              q_req_i,
  input  logic [ADDR_W-1:0] q_addr_i,
  input  logic [LEN_W-1:0]  q_len_i,
  output logic              q_gnt_o,
  output logic              q_valid_o,
  output logic              q_last_o,
  output logic [DATA_W-1:0] q_data_o,
  output logic              select_T_o,
  output logic [ADDR_W-1:0] addr_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_r;
  logic              owner_t_r;   // 1 = current burst belongs to T
  logic [LEN_W-1:0]  len_r;       // latched burst length minus one
  logic [LEN_W-1:0]  cnt_r;       // index of the word registered at the next RUN edge
`ifndef SW_ARB_FIXED_PRI_EN
  logic              last_t_r;    // 1 = T was served by the most recent grant
`endif
  logic              win_t_s;     // 1 = T wins the current arbitration
  logic [LEN_W-1:0]  win_len_s;   // length field of the winner

  // Choose the winner among the raised requests
  always_comb begin
    win_t_s = 1'b0;
    if (t_req_i && q_req_i) begin
`ifdef SW_ARB_FIXED_PRI_EN
      win_t_s = 1'b0;
`else
      win_t_s = ~last_t_r;
`endif
    end else if (t_req_i) begin
      win_t_s = 1'b1;
    end else begin
      win_t_s = 1'b0;
    end
    win_len_s = win_t_s ? t_len_i : q_len_i;
  end

  // Burst sequencer: grant, address issue and routing of returned words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      owner_t_r  <= 1'b0;
      len_r      <= {LEN_W{1'b0}};
      cnt_r      <= {LEN_W{1'b0}};
`ifndef SW_ARB_FIXED_PRI_EN
      last_t_r   <= 1'b1;
`endif
      t_gnt_o    <= 1'b0;
      t_valid_o  <= 1'b0;
      t_last_o   <= 1'b0;
      t_data_o   <= {DATA_W{1'b0}};
      q_gnt_o    <= 1'b0;
      q_valid_o  <= 1'b0;
      q_last_o   <= 1'b0;
      q_data_o   <= {DATA_W{1'b0}};
      select_T_o <= 1'b0;
      addr_o     <= {ADDR_W{1'b0}};
      busy_o     <= 1'b0;
    end else begin
      t_gnt_o <= 1'b0;
      q_gnt_o <= 1'b0;
      case (state_r)
        IDLE: begin
          t_valid_o <= 1'b0;
          t_last_o  <= 1'b0;
          t_data_o  <= {DATA_W{1'b0}};
          q_valid_o <= 1'b0;
          q_last_o  <= 1'b0;
          q_data_o  <= {DATA_W{1'b0}};
          if (t_req_i || q_req_i) begin
            t_gnt_o    <= win_t_s;
            q_gnt_o    <= ~win_t_s;
            owner_t_r  <= win_t_s;
            select_T_o <= win_t_s;
            addr_o     <= win_t_s ? t_addr_i : q_addr_i;
            len_r      <= win_len_s;
            cnt_r      <= {LEN_W{1'b0}};
            busy_o     <= 1'b1;
`ifndef SW_ARB_FIXED_PRI_EN
            last_t_r   <= win_t_s;
`endif
            // a single-word burst has already issued its only address
            state_r    <= (win_len_s == {LEN_W{1'b0}}) ? DRAIN : RUN;
          end else begin
            busy_o  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          t_valid_o <= owner_t_r;
          q_valid_o <= ~owner_t_r;
          t_last_o  <= 1'b0;
          q_last_o  <= 1'b0;
          t_data_o  <= owner_t_r ? data_i : {DATA_W{1'b0}};
          q_data_o  <= owner_t_r ? {DATA_W{1'b0}} : data_i;
          addr_o    <= addr_o + {{(ADDR_W-1){1'b0}}, 1'b1};
          cnt_r     <= cnt_r + {{(LEN_W-1){1'b0}}, 1'b1};
          // the address for word len is issued at this edge
          if (cnt_r == (len_r - {{(LEN_W-1){1'b0}}, 1'b1})) begin
            state_r <= DRAIN;
          end else begin
            state_r <= RUN;
          end
        end
        DRAIN: begin
          t_valid_o <= owner_t_r;
          q_valid_o <= ~owner_t_r;
          t_last_o  <= owner_t_r;
          q_last_o  <= ~owner_t_r;
          t_data_o  <= owner_t_r ? data_i : {DATA_W{1'b0}};
          q_data_o  <= owner_t_r ? {DATA_W{1'b0}} : data_i;
          busy_o    <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          t_valid_o <= 1'b0;
          t_last_o  <= 1'b0;
          q_valid_o <= 1'b0;
          q_last_o  <= 1'b0;
          busy_o    <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sw_mem_arbiter.sv
// Self-checking bench for sw_mem_arbiter: directed steps then random traffic,
// compared against a burst-timeline reference model.
module tb_sw_mem_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 8;
  localparam int AN     = 1 << ADDR_W;

  logic              clk;
  logic              rst_n;
  logic              t_req_i;
  logic [ADDR_W-1:0] t_addr_i;
  logic [LEN_W-1:0]  t_len_i;
  logic              t_gnt_o, t_valid_o, t_last_o;
  logic [DATA_W-1:0] t_data_o;
  logic              q_req_i;
  logic [ADDR_W-1:0] q_addr_i;
  logic [LEN_W-1:0]  q_len_i;
  logic              q_gnt_o, q_valid_o, q_last_o;
  logic [DATA_W-1:0] q_data_o;
  logic              select_T_o;
  logic [ADDR_W-1:0] addr_o;
  logic [DATA_W-1:0] data_i;
  logic              busy_o;

  sw_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .t_req_i(t_req_i), .t_addr_i(t_addr_i), .t_len_i(t_len_i),
    .t_gnt_o(t_gnt_o), .t_valid_o(t_valid_o), .t_last_o(t_last_o), .t_data_o(t_data_o),
    .q_req_i(q_req_i), .q_addr_i(q_addr_i), .q_len_i(q_len_i),
    .q_gnt_o(q_gnt_o), .q_valid_o(q_valid_o), .q_last_o(q_last_o), .q_data_o(q_data_o),
    .select_T_o(select_T_o), .addr_o(addr_o), .data_i(data_i), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] t_mem [AN];
  logic [DATA_W-1:0] q_mem [AN];

  int n_vec = 0;
  int n_err = 0;

  // reference model: one burst timeline (j = edges since acceptance)
  bit m_active;
  bit m_owner_t;
  int m_base, m_len, m_j;
  bit m_last_t;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_last_t = 1'b1;
    m_j      = 0;
  endtask

  task automatic model_edge(bit rs, bit tr, bit qr, int ta, int tl, int qa, int ql);
    bit win_t;
    if (!rs) begin
      model_reset();
      return;
    end
    if (m_active) begin
      m_j++;
      if (m_j > m_len + 1) m_active = 1'b0;
    end
    if (!m_active && (tr || qr)) begin
      if (tr && qr) begin
`ifdef SW_ARB_FIXED_PRI_EN
        win_t = 1'b0;
`else
        win_t = !m_last_t;
`endif
      end else begin
        win_t = tr;
      end
      m_last_t  = win_t;
      m_active  = 1'b1;
      m_owner_t = win_t;
      m_base    = win_t ? ta : qa;
      m_len     = win_t ? tl : ql;
      m_j       = 0;
    end
  endtask

  task automatic check_outputs();
    bit vt, vq, eb;
    int jj;
    jj = (m_j < m_len) ? m_j : m_len;
    eb = m_active && (m_j <= m_len);
    vt = m_active && m_owner_t && (m_j >= 1) && (m_j <= m_len + 1);
    vq = m_active && !m_owner_t && (m_j >= 1) && (m_j <= m_len + 1);
    chk("t_gnt", t_gnt_o, m_active && m_owner_t && (m_j == 0));
    chk("q_gnt", q_gnt_o, m_active && !m_owner_t && (m_j == 0));
    chk("busy", busy_o, eb);
    chk("t_valid", t_valid_o, vt);
    chk("q_valid", q_valid_o, vq);
    chk("t_last", t_last_o, vt && (m_j == m_len + 1));
    chk("q_last", q_last_o, vq && (m_j == m_len + 1));
    chk("valid_overlap", t_valid_o && q_valid_o, 1'b0);
    if (vt) chk("t_data", t_data_o, t_mem[(m_base + m_j - 1) % AN]);
    if (vq) chk("q_data", q_data_o, q_mem[(m_base + m_j - 1) % AN]);
    if (m_active && !m_owner_t) chk("t_data_nonowner", t_data_o, 0);
    if (m_active && m_owner_t) chk("q_data_nonowner", q_data_o, 0);
    if (eb) begin
      chk("select_T", select_T_o, m_owner_t);
      chk("addr", addr_o, (m_base + jj) % AN);
    end
    if (!rst_n) begin
      chk("rst_select_T", select_T_o, 0);
      chk("rst_addr", addr_o, 0);
      chk("rst_t_data", t_data_o, 0);
      chk("rst_q_data", q_data_o, 0);
    end
  endtask

  // one clock: model the edge, check #1 later, answer SRAM read, drop granted reqs
  task automatic tick();
    bit rs, tr, qr;
    int ta, tl, qa, ql;
    rs = rst_n; tr = t_req_i; qr = q_req_i;
    ta = int'(t_addr_i); tl = int'(t_len_i);
    qa = int'(q_addr_i); ql = int'(q_len_i);
    @(posedge clk);
    model_edge(rs, tr, qr, ta, tl, qa, ql);
    #1;
    check_outputs();
    data_i = select_T_o ? t_mem[addr_o] : q_mem[addr_o];
    if (m_active && m_j == 0) begin
      if (m_owner_t) begin
        t_req_i  = 1'b0;
        t_addr_i = ADDR_W'($urandom);
        t_len_i  = LEN_W'($urandom);
      end else begin
        q_req_i  = 1'b0;
        q_addr_i = ADDR_W'($urandom);
        q_len_i  = LEN_W'($urandom);
      end
    end
  endtask

  task automatic ticks(int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic req_t(int a, int l);
    t_req_i = 1'b1; t_addr_i = ADDR_W'(a); t_len_i = LEN_W'(l);
  endtask

  task automatic req_q(int a, int l);
    q_req_i = 1'b1; q_addr_i = ADDR_W'(a); q_len_i = LEN_W'(l);
  endtask

  initial begin
    for (int i = 0; i < AN; i++) begin
      t_mem[i] = DATA_W'($urandom);
      q_mem[i] = DATA_W'($urandom);
    end
    rst_n = 1'b0;
    t_req_i = 1'b0; t_addr_i = '0; t_len_i = '0;
    q_req_i = 1'b0; q_addr_i = '0; q_len_i = '0;
    data_i = '0;
    model_reset();

    // reset state
    ticks(3);
    #2 rst_n = 1'b1;
    ticks(2);

    // single T burst, base 10, four words
    req_t(10, 3);
    ticks(8);

    // ties: Q then T (round-robin), repeated
    for (int r = 0; r < 3; r++) begin
      req_t(40 + r * 8, 1);
      req_q(80 + r * 8, 1);
      ticks(9);
    end

    // address wrap at the top of the SRAM
    req_q(AN - 2, 3);
    ticks(8);

    // single-word burst
    req_t(300, 0);
    ticks(4);

    // longest burst: 256 words
    req_q(700, 255);
    ticks(262);

    // reset asserted after the second word of an 8-word burst
    req_q(100, 7);
    ticks(3);
    #1 rst_n = 1'b0;
    model_reset();
    #1 check_outputs();
    ticks(2);
    #2 rst_n = 1'b1;
    ticks(4);
    req_t(200, 2);
    ticks(6);

    // Q raised during a T burst and held until served
    req_t(500, 5);
    ticks(2);
    req_q(600, 2);
    ticks(14);

    // random traffic
    for (int c = 0; c < 2500; c++) begin
      if (!t_req_i && ($urandom % 8) == 0) begin
        req_t(int'($urandom % AN), ($urandom % 16 == 0) ? int'($urandom % 256) : int'($urandom % 6));
      end else if (t_req_i && ($urandom % 40) == 0) begin
        t_req_i = 1'b0;
      end
      if (!q_req_i && ($urandom % 8) == 0) begin
        req_q(int'($urandom % AN), ($urandom % 16 == 0) ? int'($urandom % 256) : int'($urandom % 6));
      end else if (q_req_i && ($urandom % 40) == 0) begin
        q_req_i = 1'b0;
      end
      tick();
    end
    t_req_i = 1'b0;
    q_req_i = 1'b0;
    ticks(270);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
